// File: rtl/axis_width_down_pkg.sv
// Shared types and helpers for the wide-to-narrow AXI-stream serializer.
package axis_width_down_pkg;

  typedef enum logic {
    StIdle,
    StBusy
  } wd_state_e;

  // Beat-index width; RATIO is at least 2, so this is simply clog2.
  function automatic int unsigned idx_bits(input int unsigned ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

endpackage

// File: rtl/axis_width_down.sv
// AXI-stream serializer: one DATA_BITS*RATIO-bit word in, RATIO DATA_BITS-bit beats out,
// one beat per clock with no bubble between back-to-back words.
module axis_width_down
  import axis_width_down_pkg::*;
#(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned RATIO     = 4,
  parameter bit          LSB_FIRST = 1'b1
) (
  input  logic                       axi_clk,
  input  logic                       axi_reset,
  input  logic                       s_axi_tvalid,
  output logic                       s_axi_tready,
  input  logic [DATA_BITS*RATIO-1:0] s_axi_tdata,
  output logic                       m_axi_tvalid,
  input  logic                       m_axi_tready,
  output logic [DATA_BITS-1:0]       m_axi_tdata,
  output logic                       m_axi_tlast
);

  localparam int unsigned     IdxW    = idx_bits(RATIO);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(RATIO - 1);

  wd_state_e                          state_q, state_d;
  logic [RATIO-1:0][DATA_BITS-1:0]    hold_q, hold_d;
  logic [IdxW-1:0]                    idx_q, idx_d;
  logic [IdxW-1:0]                    sel;
  logic                               busy, last;
  logic                               s_fire, m_fire;

  always_ff @(posedge axi_clk) begin
    if (axi_reset) begin
      state_q <= StIdle;
      idx_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    s_fire  = s_axi_tvalid && s_axi_tready;
    m_fire  = busy && m_axi_tready;
    state_d = state_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
    // A load can only coincide with a beat transfer on the last beat, so it takes priority.
    if (s_fire) begin
      hold_d  = s_axi_tdata;
      idx_d   = '0;
      state_d = StBusy;
    end else if (m_fire) begin
      if (last) begin
        state_d = StIdle;
        idx_d   = '0;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  always_comb begin
    busy         = (state_q == StBusy);
    last         = busy && (idx_q == LastIdx);
    sel          = LSB_FIRST ? idx_q : (LastIdx - idx_q);
    m_axi_tvalid = busy;
    m_axi_tlast  = last;
    m_axi_tdata  = busy ? hold_q[sel] : '0;
    // Deliberate combinational m_axi_tready -> s_axi_tready path for zero-bubble reload.
    s_axi_tready = !axi_reset && (!busy || (last && m_axi_tready));
  end

endmodule

// File: tb/tb_axis_width_down.sv
// Scoreboard bench for axis_width_down: directed cases from the test plan plus random traffic.
module tb_axis_width_down;

  logic axi_clk = 1'b0;
  logic axi_reset = 1'b1;
  always #5 axi_clk = ~axi_clk;

  // Main DUT: DATA_BITS=8, RATIO=4, LSB first.
  logic        s_tvalid, s_tready, m_tvalid, m_tready, m_tlast;
  logic [31:0] s_tdata;
  logic [7:0]  m_tdata;
  // MSB-first DUT.
  logic        b_stvalid, b_stready, b_mtvalid, b_mtready, b_mtlast;
  logic [31:0] b_sdata;
  logic [7:0]  b_mtdata;
  // RATIO=3 DUT.
  logic        c_stvalid, c_stready, c_mtvalid, c_mtready, c_mtlast;
  logic [23:0] c_sdata;
  logic [7:0]  c_mtdata;

  axis_width_down #(.DATA_BITS(8), .RATIO(4), .LSB_FIRST(1'b1)) u_dut (
    .axi_clk(axi_clk), .axi_reset(axi_reset),
    .s_axi_tvalid(s_tvalid), .s_axi_tready(s_tready), .s_axi_tdata(s_tdata),
    .m_axi_tvalid(m_tvalid), .m_axi_tready(m_tready), .m_axi_tdata(m_tdata),
    .m_axi_tlast(m_tlast)
  );

  axis_width_down #(.DATA_BITS(8), .RATIO(4), .LSB_FIRST(1'b0)) u_msb (
    .axi_clk(axi_clk), .axi_reset(axi_reset),
    .s_axi_tvalid(b_stvalid), .s_axi_tready(b_stready), .s_axi_tdata(b_sdata),
    .m_axi_tvalid(b_mtvalid), .m_axi_tready(b_mtready), .m_axi_tdata(b_mtdata),
    .m_axi_tlast(b_mtlast)
  );

  axis_width_down #(.DATA_BITS(8), .RATIO(3), .LSB_FIRST(1'b1)) u_r3 (
    .axi_clk(axi_clk), .axi_reset(axi_reset),
    .s_axi_tvalid(c_stvalid), .s_axi_tready(c_stready), .s_axi_tdata(c_sdata),
    .m_axi_tvalid(c_mtvalid), .m_axi_tready(c_mtready), .m_axi_tdata(c_mtdata),
    .m_axi_tlast(c_mtlast)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [8:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: beat k of a word is byte k (LSB first) or byte ratio-1-k (MSB first).
  function automatic logic [7:0] beat_of(input logic [31:0] w, input int k, input int ratio,
                                         input bit lsb);
    int s;
    s = lsb ? k : ratio - 1 - k;
    return 8'(w >> (8 * s));
  endfunction

  // Monitor / scoreboard for the main DUT, sampled mid-cycle on the falling edge.
  logic       stall_pend = 1'b0;
  logic [7:0] stall_d;
  logic       stall_l;
  logic [8:0] e;
  always @(negedge axi_clk) begin
    if (axi_reset) begin
      exp_q.delete();
      stall_pend = 1'b0;
    end else begin
      if (stall_pend) begin
        chk("stall_valid", 32'(m_tvalid), 32'd1);
        chk("stall_data", 32'(m_tdata), 32'(stall_d));
        chk("stall_last", 32'(m_tlast), 32'(stall_l));
      end
      stall_pend = m_tvalid && !m_tready;
      stall_d    = m_tdata;
      stall_l    = m_tlast;
      if (!m_tvalid) begin
        chk("idle_data", 32'(m_tdata), 32'd0);
        chk("idle_last", 32'(m_tlast), 32'd0);
      end
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL beat_unexpected: got %0h, expected no beat at %0t", m_tdata, $time);
        end else begin
          e = exp_q.pop_front();
          chk("beat_data", 32'(m_tdata), 32'(e[7:0]));
          chk("beat_last", 32'(m_tlast), 32'(e[8]));
        end
      end
      if (s_tvalid && s_tready) begin
        for (int k = 0; k < 4; k++) exp_q.push_back({k == 3, beat_of(s_tdata, k, 4, 1'b1)});
      end
    end
  end

  task automatic wait_accept(input int which, input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge axi_clk);
      case (which)
        0:       ok = s_tready;
        1:       ok = b_stready;
        default: ok = c_stready;
      endcase
    end
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: ready stayed low, expected high within 200 cycles", name);
    end
  endtask

  task automatic send_word(input logic [31:0] w);
    s_tvalid = 1'b1;
    s_tdata  = w;
    wait_accept(0, "send_timeout");
    @(posedge axi_clk); #1;
    s_tvalid = 1'b0;
    s_tdata  = $urandom;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1);
  end

  initial begin
    s_tvalid = 0; s_tdata = '0; m_tready = 1;
    b_stvalid = 0; b_sdata = '0; b_mtready = 1;
    c_stvalid = 0; c_sdata = '0; c_mtready = 1;
    repeat (3) @(posedge axi_clk);
    #1;
    chk("rst_tvalid", 32'(m_tvalid), 32'd0);
    chk("rst_tdata", 32'(m_tdata), 32'd0);
    chk("rst_tlast", 32'(m_tlast), 32'd0);
    chk("rst_sready", 32'(s_tready), 32'd0);
    axi_reset = 0;
    @(negedge axi_clk);
    chk("sready_after_rst", 32'(s_tready), 32'd1);
    @(posedge axi_clk); #1;

    // Single word, full downstream rate.
    send_word(32'hDDCCBBAA);
    for (int k = 0; k < 4; k++) begin
      @(negedge axi_clk);
      chk("single_tvalid", 32'(m_tvalid), 32'd1);
      chk("single_sready", 32'(s_tready), 32'(k == 3));
    end
    @(negedge axi_clk);
    chk("single_done", 32'(m_tvalid), 32'd0);
    @(posedge axi_clk); #1;

    // Back-to-back words with tvalid held high: 8 beats, no idle cycle.
    s_tvalid = 1; s_tdata = 32'h04030201;
    wait_accept(0, "b2b_first");
    @(posedge axi_clk); #1;
    s_tdata = 32'h08070605;
    for (int c = 1; c <= 8; c++) begin
      @(negedge axi_clk);
      chk("b2b_tvalid", 32'(m_tvalid), 32'd1);
      if (c == 4) begin
        chk("b2b_reload", 32'(s_tready), 32'd1);
        @(posedge axi_clk); #1;
        s_tvalid = 0;
      end
    end
    @(negedge axi_clk);
    chk("b2b_done", 32'(m_tvalid), 32'd0);
    @(posedge axi_clk); #1;

    // Backpressure for three cycles while BB is presented.
    send_word(32'hDDCCBBAA);
    @(posedge axi_clk); #1;
    m_tready = 0;
    repeat (3) begin
      @(negedge axi_clk);
      chk("bp_hold", 32'(m_tdata), 32'hBB);
    end
    @(posedge axi_clk); #1;
    m_tready = 1;
    repeat (5) @(posedge axi_clk);
    #1;

    // Reset in the middle of a word.
    send_word(32'hDDCCBBAA);
    @(posedge axi_clk); #1;
    axi_reset = 1;
    @(posedge axi_clk); #1;
    chk("rstmid_tvalid", 32'(m_tvalid), 32'd0);
    chk("rstmid_tdata", 32'(m_tdata), 32'd0);
    chk("rstmid_tlast", 32'(m_tlast), 32'd0);
    chk("rstmid_sready", 32'(s_tready), 32'd0);
    axi_reset = 0;
    @(negedge axi_clk);
    chk("rstmid_sready_rel", 32'(s_tready), 32'd1);
    @(posedge axi_clk); #1;
    send_word(32'h0000EE55);
    repeat (6) @(posedge axi_clk);
    #1;

    // Random traffic on both sides.
    fork
      begin
        for (int n = 0; n < 60; n++) begin
          int g;
          g = $urandom_range(0, 2);
          repeat (g) begin
            @(posedge axi_clk); #1;
          end
          send_word($urandom);
        end
      end
      begin
        for (int n = 0; n < 400; n++) begin
          m_tready = ($urandom_range(0, 9) < 7);
          @(posedge axi_clk); #1;
        end
        m_tready = 1;
      end
    join
    for (int i = 0; i < 30; i++) begin
      if (exp_q.size() == 0 && !m_tvalid) break;
      @(posedge axi_clk); #1;
    end
    chk("drain_empty", 32'(exp_q.size()), 32'd0);

    // MSB-first ordering.
    b_stvalid = 1; b_sdata = 32'h11223344;
    wait_accept(1, "msb_accept");
    @(posedge axi_clk); #1;
    b_stvalid = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge axi_clk);
      chk("msb_valid", 32'(b_mtvalid), 32'd1);
      chk("msb_data", 32'(b_mtdata), 32'(beat_of(32'h11223344, k, 4, 1'b0)));
      chk("msb_last", 32'(b_mtlast), 32'(k == 3));
    end
    @(negedge axi_clk);
    chk("msb_done", 32'(b_mtvalid), 32'd0);
    @(posedge axi_clk); #1;

    // RATIO=3, two words back to back: the index must wrap after 2.
    c_stvalid = 1; c_sdata = 24'hC0B0A0;
    wait_accept(2, "r3_accept");
    @(posedge axi_clk); #1;
    c_sdata = 24'h332211;
    for (int k = 0; k < 6; k++) begin
      logic [31:0] w;
      w = (k < 3) ? 32'h00C0B0A0 : 32'h00332211;
      @(negedge axi_clk);
      chk("r3_valid", 32'(c_mtvalid), 32'd1);
      chk("r3_data", 32'(c_mtdata), 32'(beat_of(w, k % 3, 3, 1'b1)));
      chk("r3_last", 32'(c_mtlast), 32'((k % 3) == 2));
      if (k == 2) begin
        chk("r3_reload", 32'(c_stready), 32'd1);
        @(posedge axi_clk); #1;
        c_stvalid = 0;
      end
    end
    @(negedge axi_clk);
    chk("r3_done", 32'(c_mtvalid), 32'd0);
    @(posedge axi_clk); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
